// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - Bin over WIDTH cycles.
// Optional SERIAL_SUBTRACTOR_ADD_MODE_EN adds a Sub port (Sub=0 adds).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             sub_q;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             bo_bit;
  logic             accept;

  assign accept = start && (state != SHIFT);

  always_comb begin
    a_bit = sa[0];
    b_bit = sb[0];
    d_bit = a_bit ^ b_bit ^ br;
    if (sub_q)
      bo_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    else
      bo_bit = (a_bit & b_bit) | (br & (a_bit ^ b_bit));
  end

  // Difference bits refill sa from the top, so sa ends up holding the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      sub_q <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      sa    <= A;
      sb    <= B;
      br    <= Bin;
      cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_q <= Sub;
`else
      sub_q <= 1'b1;
`endif
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == SHIFT) begin
      sa  <= {d_bit, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      br  <= bo_bit;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        D     <= {d_bit, sa[WIDTH-1:1]};
        Bout  <= bo_bit;
      end
    end else begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor; expected results queued at start.
// Define SERIAL_SUBTRACTOR_ADD_MODE_EN to also exercise add mode.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         sub = 1'b1;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;
  int   last_done = 0;
  int   prev_done_cyc = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (a),
    .B    (b),
    .Bin  (bin),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .Sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .D    (d),
    .Bout (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s, input int acc);
    exp_t e;
    logic [W:0] r;
    if (s) r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.d    = r[W-1:0];
    e.bout = r[W];
    e.acc  = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        check("done_with_busy", {31'd0, busy}, 0);
        check("done_twice", {31'd0, prev_done}, 0);
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("D", {24'd0, d}, {24'd0, e.d});
          check("Bout", {31'd0, bout}, {31'd0, e.bout});
          check("latency", cyc - e.acc, W);
          check("busy_cycles", busy_run, W);
        end
        busy_run = 0;
        prev_done_cyc = last_done;
        last_done = cyc;
      end
    end
    prev_done = done;
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s, input logic push);
    a   = x;
    b   = y;
    bin = ci;
    sub = s;
    start = 1'b1;
    if (push) q.push_back(model(x, y, ci, s, cyc + 1));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
    @(posedge clk); #1;
    drive(x, y, ci, s, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_D", {24'd0, d}, 0);
    check("rst_Bout", {31'd0, bout}, 0);

    run_op(8'h05, 8'h03, 1'b0, 1'b1);
    run_op(8'h03, 8'h05, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b1);

    // start pulsed mid-shift must be ignored
    @(posedge clk); #1;
    drive(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    drive(8'h10, 8'h10, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    @(posedge clk); #1;
    check("b2b_gap", last_done - prev_done_cyc, W + 1);

    run_op(8'h55, 8'h0F, 1'b0, 1'b1);

    // abandon an operation with reset
    @(posedge clk); #1;
    drive(8'h55, 8'h0F, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_D", {24'd0, d}, 0);
    check("mid_rst_Bout", {31'd0, bout}, 0);
    repeat (20) @(posedge clk);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(posedge clk);
    check("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor that computes D = A − B − Bin over WIDTH clock cycles using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the team's full-adder arithmetic cells. It is meant for area-constrained datapaths where a ripple subtractor of full width is not wanted. Operands are loaded in parallel on a start/done handshake, and the result is presented in parallel.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- Bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while state is SHIFT
- done  output  1  one-cycle pulse, result valid
- D  output  WIDTH  difference, registered, held until next completion
- Bout  output  1  borrow-out, registered, held with D

## Operation
- States:
  - IDLE: no operation in progress.
  - SHIFT: bits are being processed; a count cnt runs 0..WIDTH−1.
  - DONE: result just completed.
- Transitions:
  - IDLE→SHIFT on start=1.
  - SHIFT→DONE when cnt=WIDTH−1.
  - DONE→SHIFT if start=1, else DONE→IDLE.
- Accepted start loads:
  - A into shift register sa.
  - B into shift register sb.
  - Bin into the borrow register.
  - cnt is cleared to 0.
- Each SHIFT cycle works on bits a=sa[0], b=sb[0], with br the current borrow register:
  - d = a ^ b ^ br
  - bo = (~a & b) | (~(a ^ b) & br)
  - d is shifted into the MSB of an internal result register.
  - sa and sb shift right by 1.
  - br is updated to bo.
  - cnt is incremented.
- On the SHIFT→DONE edge, D receives the complete result and Bout receives the final bo.
- D and Bout change only on that edge and on reset; they hold their values through IDLE and subsequent SHIFT.
- start is ignored in SHIFT: no reload, and no effect on the in-flight result.
- A, B and Bin are don't-care outside the accepting edge.
- Arithmetic is modulo 2^WIDTH. Bout=1 exactly when A < B + Bin, treating A and B as unsigned.

## Timing
- Reset values: state=IDLE, busy=0, done=0, D=0, Bout=0, cnt=0, internal registers 0.
- Reset has priority over all other inputs, including mid-SHIFT. The operation is abandoned and done does not fire.
- Latency and handshake, with start accepted at edge k:
  - busy=1 from edge k through edge k+WIDTH.
  - done=1 and D/Bout valid from edge k+WIDTH until edge k+WIDTH+1.
  - Start-to-done latency is WIDTH cycles.
- Back-to-back: start=1 while done=1 is accepted. busy rises at the next edge, giving a throughput of one result per WIDTH+1 cycles.
- done is never high in two consecutive cycles.
- done and busy are never both high.

## Configuration
- Macro: SERIAL_SUBTRACTOR_ADD_MODE_EN.
- Defined:
  - Adds input port Sub (1 bit), captured on accepted start.
  - Sub=1 gives subtract behaviour exactly as described above.
  - Sub=0 gives D = A + B + Bin, with the per-bit cell d = a^b^c and c' = (a&b)|(c&(a^b)), and Bout = carry-out.
- Undefined:
  - No Sub port; subtract only.
  - Behaviour is identical to the defined case with Sub=1.

## Test plan
- WIDTH=8. Reset, then start with A=0x05, B=0x03, Bin=0. Required:
  - busy for 8 cycles.
  - done pulse exactly 8 cycles after the accepting edge.
  - D=0x02, Bout=0.
- A=0x03, B=0x05, Bin=0 → D=0xFE, Bout=1.
- A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1.
- A=0xFF, B=0xFF, Bin=1 → D=0xFF, Bout=1.
- Ignored start, then back-to-back:
  - Start A=0x80, B=0x01, Bin=0.
  - Pulse start with A=0x00, B=0x00 at cycle 3 of SHIFT → ignored; result D=0x7F, Bout=0.
  - Assert start in the done cycle with A=0x10, B=0x10, Bin=0 → next done gives D=0x00, Bout=0, 9 cycles after the previous done.
- Reset mid-op and add mode:
  - Start A=0x55, B=0x0F; assert reset at cycle 4 → busy=0, done=0, D=0x00, Bout=0, with no done pulse afterward.
  - With SERIAL_SUBTRACTOR_ADD_MODE_EN defined: Sub=0, A=0xFF, B=0x01, Bin=0 → D=0x00, Bout=1.
